// File: rtl/game_logic_multi_pkg.sv
// Shared types and constants for the multi-coin game-state controller.
package game_logic_multi_pkg;

  typedef enum logic [2:0] {
    S_WAIT, S_PLAY, S_RESPAWN, S_PAUSE, S_WIN, S_LOSE, S_PREWAIT
  } state_e;

  localparam logic [3:0] ST_WAIT = 4'b1000;
  localparam logic [3:0] ST_PLAY = 4'b0100;
  localparam logic [3:0] ST_WIN  = 4'b0010;
  localparam logic [3:0] ST_LOSE = 4'b0001;

  localparam logic [7:0] KEY_SPACE = 8'h2c;
  localparam logic [7:0] KEY_P     = 8'h13;

  // Stickman geometry; coin windows are relative to the stickman box.
  localparam int STICK_W     = 50;
  localparam int STICK_H     = 50;
  localparam int FALL_LINE   = 470;
  localparam int SCREEN_LEFT = 100;
  localparam int COIN_X_LO   = 10;
  localparam int COIN_X_HI   = 46;
  localparam int COIN_Y_LO   = 10;
  localparam int COIN_Y_HI   = 74;

  // PREWAIT is the "release the start key" gap and shows as wait.
  function automatic logic [3:0] status_of(state_e s);
    case (s)
      S_PLAY, S_RESPAWN, S_PAUSE: status_of = ST_PLAY;
      S_WIN:                      status_of = ST_WIN;
      S_LOSE:                     status_of = ST_LOSE;
      default:                    status_of = ST_WAIT;
    endcase
  endfunction

endpackage

// File: rtl/game_logic_multi_coin_hit_detect.sv
// Pure overlap test of one coin against the stickman collection window.
module coin_hit_detect
  import game_logic_multi_pkg::*;
(
  input  logic [11:0] frame_cnt_i,
  input  logic [9:0]  stick_top_i,
  input  logic [12:0] coin_x_i,
  input  logic [9:0]  coin_y_i,
  output logic        hit_o
);
  logic [12:0] left, top, cy;

  always_comb begin
    left  = 13'(SCREEN_LEFT) + {1'b0, frame_cnt_i};
    top   = {3'b0, stick_top_i};
    cy    = {3'b0, coin_y_i};
    hit_o = (coin_x_i > left + 13'(COIN_X_LO)) && (coin_x_i < left + 13'(COIN_X_HI)) &&
            (cy > top + 13'(COIN_Y_LO)) && (cy < top + 13'(COIN_Y_HI));
  end
endmodule

// File: rtl/game_logic_multi.sv
// Game-state controller: status FSM, coin clearing, score, lives, pause and respawn grace.
module game_logic_multi
  import game_logic_multi_pkg::*;
#(
  parameter int          NUM_COINS      = 3,
  parameter int          NUM_LIVES      = 3,
  parameter int          WIN_FRAME      = 3000,
  parameter int          RESPAWN_FRAMES = 90,
  parameter logic [7:0]  START_KEY      = KEY_SPACE,
  parameter logic [7:0]  PAUSE_KEY      = KEY_P,
  parameter int          SCORE_W        = 8
) (
  input  logic                        Clk,
  input  logic                        Reset_n,
  input  logic                        frame_clk,
  input  logic [7:0]                  keycode,
  input  logic [9:0]                  StickmanTop,
  input  logic [9:0]                  GroundY,
  input  logic [11:0]                 frame_counter,
  input  logic [NUM_COINS-1:0][12:0]  CoinFrameX,
  input  logic [NUM_COINS-1:0][9:0]   CoinY,
  output logic [NUM_COINS-1:0]        CoinStatus,
  output logic [3:0]                  status,
  output logic                        paused,
  output logic                        respawning,
  output logic [2:0]                  lives,
  output logic [SCORE_W-1:0]          score
);
  localparam int RW = $clog2(RESPAWN_FRAMES + 1);
  localparam int CW = $clog2(NUM_COINS + 1);

  state_e               state_q, state_d;
  logic [NUM_COINS-1:0] coins_q, coins_d, collected, newly;
  logic [2:0]           lives_q, lives_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [SCORE_W:0]     score_sum;
  logic [CW-1:0]        new_cnt;
  logic [RW-1:0]        rcnt_q, rcnt_d;
  logic [7:0]           key_prev_q;
  logic                 frame_prev_q;
  logic                 start_press, pause_press, frame_tick, hit;
  logic [10:0]          feet;

  for (genvar g = 0; g < NUM_COINS; g++) begin : g_coin
    coin_hit_detect u_coin (
      .frame_cnt_i (frame_counter),
      .stick_top_i (StickmanTop),
      .coin_x_i    (CoinFrameX[g]),
      .coin_y_i    (CoinY[g]),
      .hit_o       (collected[g])
    );
  end

  always_comb begin
    start_press = (keycode == START_KEY) && (key_prev_q != START_KEY);
    pause_press = (keycode == PAUSE_KEY) && (key_prev_q != PAUSE_KEY);
    frame_tick  = frame_clk && !frame_prev_q;
    feet        = {1'b0, StickmanTop} + 11'(STICK_H);
    hit         = (feet > {1'b0, GroundY}) || (feet >= 11'(FALL_LINE));
  end

  always_comb begin
    state_d   = state_q;
    coins_d   = coins_q;
    lives_d   = lives_q;
    score_d   = score_q;
    rcnt_d    = rcnt_q;
    newly     = '0;
    new_cnt   = '0;
    score_sum = '0;
    // Coins only clear while the stickman is live; the end screens keep the final set.
    if (state_q == S_PLAY || state_q == S_RESPAWN) begin
      newly   = coins_q & collected;
      coins_d = coins_q & ~collected;
      for (int i = 0; i < NUM_COINS; i++) new_cnt = new_cnt + CW'(newly[i]);
      score_sum = {1'b0, score_q} + (SCORE_W+1)'(new_cnt);
      score_d   = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
    end
    case (state_q)
      S_WAIT: if (start_press) begin
        state_d = S_PLAY;
        coins_d = '1;
        lives_d = 3'(NUM_LIVES);
        score_d = '0;
      end
      S_PLAY: begin
        if (hit) begin
          if (lives_q == 3'd1) begin
            state_d = S_LOSE;
            lives_d = '0;
          end else begin
            state_d = S_RESPAWN;
            lives_d = lives_q - 3'd1;
            rcnt_d  = '0;
          end
        end else if (frame_counter >= 12'(WIN_FRAME)) state_d = S_WIN;
        else if (pause_press)                          state_d = S_PAUSE;
      end
      S_RESPAWN: if (frame_tick) begin
        rcnt_d = rcnt_q + RW'(1);
        if (rcnt_d == RW'(RESPAWN_FRAMES)) state_d = S_PLAY;
      end
      S_PAUSE:      if (pause_press) state_d = S_PLAY;
      S_WIN, S_LOSE: if (start_press) state_d = S_PREWAIT;
      S_PREWAIT:    if (keycode != START_KEY) state_d = S_WAIT;
      default:      state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q      <= S_WAIT;
      coins_q      <= '1;
      lives_q      <= 3'(NUM_LIVES);
      score_q      <= '0;
      rcnt_q       <= '0;
      key_prev_q   <= '0;
      frame_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      coins_q      <= coins_d;
      lives_q      <= lives_d;
      score_q      <= score_d;
      rcnt_q       <= rcnt_d;
      key_prev_q   <= keycode;
      frame_prev_q <= frame_clk;
    end
  end

  assign CoinStatus = coins_q;
  assign lives      = lives_q;
  assign score      = score_q;
  assign status     = status_of(state_q);
  assign paused     = (state_q == S_PAUSE);
  assign respawning = (state_q == S_RESPAWN);
endmodule
